// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Optional madd/maddu accumulate support is enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDU_RD
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic { S_IDLE, S_RUN } state_t;
    // What the commit edge does with the pending result.
    typedef enum logic [1:0] { PK_LOAD, PK_KEEP, PK_ACC } kind_t;

    state_t         state_q;
    kind_t          kind_q, kind_d;
    logic           busy_q;
    logic [CW-1:0]  cnt_q, cyc_d;
    logic [63:0]    pend_q, res_d;
    logic [31:0]    hi_q, lo_q;
    logic           long_op;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, uq, ur, uq_u, ur_u, quo_s, rem_s, divu_b;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign abs_a  = A[31] ? (~A + 32'd1) : A;
    assign abs_b  = (B == 32'd0) ? 32'd1 : (B[31] ? (~B + 32'd1) : B);
    assign uq     = abs_a / abs_b;
    assign ur     = abs_a % abs_b;
    assign quo_s  = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
    assign rem_s  = A[31] ? (~ur + 32'd1) : ur;
    assign divu_b = (B == 32'd0) ? 32'd1 : B;
    assign uq_u   = A / divu_b;
    assign ur_u   = A % divu_b;

    always_comb begin
        res_d   = '0;
        kind_d  = PK_LOAD;
        cyc_d   = CW'(MULT_CYCLES);
        long_op = 1'b0;
        case (E_MDUOp)
            OP_MULT:  begin long_op = 1'b1; res_d = prod_s; end
            OP_MULTU: begin long_op = 1'b1; res_d = prod_u; end
            OP_DIV: begin
                long_op = 1'b1;
                cyc_d   = CW'(DIV_CYCLES);
                res_d   = {rem_s, quo_s};
                if (B == 32'd0) kind_d = PK_KEEP;
            end
            OP_DIVU: begin
                long_op = 1'b1;
                cyc_d   = CW'(DIV_CYCLES);
                res_d   = {ur_u, uq_u};
                if (B == 32'd0) kind_d = PK_KEEP;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin long_op = 1'b1; res_d = prod_s; kind_d = PK_ACC; end
            OP_MADDU: begin long_op = 1'b1; res_d = prod_u; kind_d = PK_ACC; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= '0;
            kind_q  <= PK_LOAD;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (E_start) begin
                        if (E_MDUOp == OP_MTHI) hi_q <= A;
                        if (E_MDUOp == OP_MTLO) lo_q <= A;
                        if (long_op) begin
                            pend_q  <= res_d;
                            kind_q  <= kind_d;
                            cnt_q   <= cyc_d;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        case (kind_q)
                            PK_LOAD: {hi_q, lo_q} <= pend_q;
                            PK_ACC:  {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
                            default: ;
                        endcase
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign E_busy   = busy_q;
    assign E_HI     = hi_q;
    assign E_LO     = lo_q;
    assign E_MDU_RD = (E_MDUOp == OP_MFHI) ? hi_q :
                      (E_MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: arithmetic, busy window, ignored starts, reset abort, madd option.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  E_MDUOp = 4'd0;
    logic        E_start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        E_busy;
    logic [31:0] E_HI, E_LO, E_MDU_RD;

    int vecs = 0;
    int errs = 0;
    int n;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_start(E_start),
        .A(A), .B(B), .E_busy(E_busy), .E_HI(E_HI), .E_LO(E_LO), .E_MDU_RD(E_MDU_RD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op for exactly one rising edge; returns at the negedge after it.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        E_MDUOp = op; A = a; B = b; E_start = 1'b1;
        @(negedge clk);
        E_start = 1'b0; E_MDUOp = 4'd0;
    endtask

    // Counts negedge samples with busy high, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (E_busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'd0, E_busy}, 32'd0);
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);
        E_MDUOp = 4'd5; #1;
        chk("rst_rd", E_MDU_RD, 32'd0);
        E_MDUOp = 4'd0;
        @(negedge clk); reset = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", E_HI, 32'hFFFF_FFFF);
        chk("mult_lo", E_LO, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", E_HI, 32'h0000_0001);
        chk("multu_lo", E_LO, 32'hFFFF_FFFE);
        E_MDUOp = 4'd5; #1;
        chk("mfhi_rd", E_MDU_RD, 32'h0000_0001);
        E_MDUOp = 4'd6; #1;
        chk("mflo_rd", E_MDU_RD, 32'hFFFF_FFFE);
        E_MDUOp = 4'd0;

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", E_LO, 32'hFFFF_FFFD);
        chk("div_hi", E_HI, 32'hFFFF_FFFF);

        issue(4'd4, 32'd7, 32'd2);
        wait_idle(n);
        chk("divu_lo", E_LO, 32'd3);
        chk("divu_hi", E_HI, 32'd1);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divovf_lo", E_LO, 32'h8000_0000);
        chk("divovf_hi", E_HI, 32'd0);

        issue(4'd7, 32'h1234, 32'd0);
        chk("mthi_busy", {31'd0, E_busy}, 32'd0);
        chk("mthi_hi", E_HI, 32'h1234);
        issue(4'd3, 32'd5, 32'd0);
        wait_idle(n);
        chk("div0_cycles", n, 32'd10);
        chk("div0_hi", E_HI, 32'h1234);
        chk("div0_lo", E_LO, 32'h8000_0000);

        // Starts arriving during busy must be dropped; 100/7 = 14 r 2.
        issue(4'd8, 32'h5555, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        E_MDUOp = 4'd8; A = 32'hAAAA; E_start = 1'b1;
        @(negedge clk);
        E_MDUOp = 4'd1; A = 32'd3; B = 32'd3;
        @(negedge clk);
        E_start = 1'b0; E_MDUOp = 4'd6; #1;
        chk("midbusy_rd", E_MDU_RD, 32'h5555);
        chk("midbusy_busy", {31'd0, E_busy}, 32'd1);
        E_MDUOp = 4'd0;
        wait_idle(n);
        chk("ign_remaining", n, 32'd6);
        chk("ign_lo", E_LO, 32'd14);
        chk("ign_hi", E_HI, 32'd2);
        repeat (8) @(negedge clk);
        chk("ign_nolate_busy", {31'd0, E_busy}, 32'd0);
        chk("ign_nolate_lo", E_LO, 32'd14);

        issue(4'd3, 32'd9, 32'd2);
        repeat (3) @(negedge clk);
        reset = 1'b0; #1;
        chk("abort_busy", {31'd0, E_busy}, 32'd0);
        chk("abort_hi", E_HI, 32'd0);
        chk("abort_lo", E_LO, 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_post_busy", {31'd0, E_busy}, 32'd0);
        chk("abort_post_hi", E_HI, 32'd0);
        chk("abort_post_lo", E_LO, 32'd0);

        issue(4'd8, 32'hFFFF_FFFF, 32'd0);
        issue(4'd7, 32'd0, 32'd0);
        issue(4'd10, 32'd1, 32'd1);
        wait_idle(n);
`ifdef MDU_MADD_EN
        chk("maddu_cycles", n, 32'd5);
        chk("maddu_hi", E_HI, 32'd1);
        chk("maddu_lo", E_LO, 32'd0);
`else
        chk("maddu_cycles", n, 32'd0);
        chk("maddu_hi", E_HI, 32'd0);
        chk("maddu_lo", E_LO, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
